// File: rtl/sr_stream_pkg.sv
// Shared defaults and state encoding for the super-resolution FIFO frame reader.
package sr_stream_pkg;

  localparam int unsigned DEF_WIDTH       = 320;
  localparam int unsigned DEF_HEIGHT      = 240;
  localparam int unsigned DEF_PIXEL_WIDTH = 24;
  localparam int unsigned DEF_COUNT_WIDTH = 10;
  localparam int unsigned FRAME_SIZE      = DEF_WIDTH * DEF_HEIGHT;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    DONE   = 2'd2
  } state_t;

endpackage

// File: rtl/sr_fifo_frame_reader_if.sv
// FIFO read port plus the outgoing pixel stream; master is the frame reader.
interface sr_fifo_frame_reader_if
  import sr_stream_pkg::*;
#(
  parameter int unsigned PIXEL_WIDTH = DEF_PIXEL_WIDTH,
  parameter int unsigned COUNT_WIDTH = DEF_COUNT_WIDTH
) ();

  logic [COUNT_WIDTH-1:0] data_count_r;
  logic                   rd_fifo;
  logic [PIXEL_WIDTH-1:0] fifo_dout;
  logic                   m_valid;
  logic                   m_ready;
  logic [PIXEL_WIDTH-1:0] m_data;
  logic                   m_sof;
  logic                   m_eol;

  modport master (
    input  data_count_r, fifo_dout, m_ready,
    output rd_fifo, m_valid, m_data, m_sof, m_eol
  );

  modport slave (
    output data_count_r, fifo_dout, m_ready,
    input  rd_fifo, m_valid, m_data, m_sof, m_eol
  );

endinterface

// File: rtl/sr_stream_skid_buf.sv
// Two-entry valid/ready buffer; the top two data bits carry the {sof, eol} tags.
module sr_stream_skid_buf #(
  parameter int unsigned DW = 26
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic [DW-1:0] din,
  input  logic          ready,
  output logic          valid,
  output logic [DW-1:0] dout,
  output logic [1:0]    occ
);

  logic [DW-1:0] slot0_q, slot0_d, slot1_q, slot1_d;
  logic [1:0]    occ_q, occ_d;
  logic          valid_q;
  logic          pop;

  // Head is always slot0; a pop that empties the buffer clears the head tags.
  always_comb begin
    slot0_d = slot0_q;
    slot1_d = slot1_q;
    occ_d   = occ_q;
    pop     = valid_q & ready;
    unique case ({push, pop})
      2'b10: begin
        if (occ_q == 2'd0) slot0_d = din;
        else               slot1_d = din;
        occ_d = occ_q + 2'd1;
      end
      2'b01: begin
        if (occ_q == 2'd2) slot0_d = slot1_q;
        else               slot0_d = {2'b00, slot0_q[DW-3:0]};
        occ_d = occ_q - 2'd1;
      end
      2'b11: begin
        if (occ_q == 2'd2) begin
          slot0_d = slot1_q;
          slot1_d = din;
        end else begin
          slot0_d = din;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      slot0_q <= '0;
      slot1_q <= '0;
      occ_q   <= 2'd0;
      valid_q <= 1'b0;
    end else begin
      slot0_q <= slot0_d;
      slot1_q <= slot1_d;
      occ_q   <= occ_d;
      valid_q <= (occ_d != 2'd0);
    end
  end

  assign valid = valid_q;
  assign dout  = slot0_q;
  assign occ   = occ_q;

endmodule

// File: rtl/sr_fifo_frame_reader.sv
// Drains the SR output FIFO into a framed valid/ready pixel stream with x/y tracking.
// Optional stall counter enabled by defining SR_READER_UNDERRUN_EN.
module sr_fifo_frame_reader
  import sr_stream_pkg::*;
#(
  parameter int unsigned WIDTH       = DEF_WIDTH,
  parameter int unsigned HEIGHT      = DEF_HEIGHT,
  parameter int unsigned PIXEL_WIDTH = DEF_PIXEL_WIDTH,
  parameter int unsigned COUNT_WIDTH = DEF_COUNT_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  enable,
  sr_fifo_frame_reader_if.master bus,
  output logic                  frame_done,
  output logic [15:0]           underrun_count
);

  localparam int unsigned FSIZE = WIDTH * HEIGHT;
  localparam int unsigned XW    = $clog2(WIDTH);
  localparam int unsigned YW    = $clog2(HEIGHT);
  localparam int unsigned IW    = $clog2(FSIZE + 1);
  localparam int unsigned DW    = PIXEL_WIDTH + 2;

  state_t          state_q, state_d;
  logic [XW-1:0]   x_q, x_d, cx;
  logic [YW-1:0]   y_q, y_d, cy;
  logic [IW-1:0]   issued_q, issued_d;
  logic            rd_q, rd_d, cap_q, frame_done_q, done_d, clr_issued;
  logic            valid, xfer, x_last, y_last, ahead;
  logic [1:0]      occ;
  logic [2:0]      inflight;
  logic [DW-1:0]   head, wr_data;

  assign xfer   = valid & bus.m_ready;
  assign x_last = (x_q == XW'(WIDTH - 1));
  assign y_last = (y_q == YW'(HEIGHT - 1));

  // Raster position of the head pixel, and of the pixel being captured behind it.
  always_comb begin
    x_d = x_q;
    y_d = y_q;
    if (xfer) begin
      if (x_last) begin
        x_d = '0;
        y_d = y_last ? '0 : y_q + YW'(1);
      end else begin
        x_d = x_q + XW'(1);
      end
    end
    ahead = ((occ - {1'b0, xfer}) != 2'd0);
    cx    = x_d;
    cy    = y_d;
    if (ahead) begin
      if (x_d == XW'(WIDTH - 1)) begin
        cx = '0;
        cy = (y_d == YW'(HEIGHT - 1)) ? '0 : y_d + YW'(1);
      end else begin
        cx = x_d + XW'(1);
      end
    end
    wr_data = {(cx == '0) && (cy == '0), (cx == XW'(WIDTH - 1)), bus.fifo_dout};
  end

  // Frame FSM and read issue; in-flight reads count against both FIFO count and buffer space.
  always_comb begin
    state_d    = state_q;
    clr_issued = 1'b0;
    done_d     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (enable) begin
          state_d    = STREAM;
          clr_issued = 1'b1;
        end
      end
      STREAM: begin
        if (xfer && x_last && y_last) begin
          state_d = DONE;
          done_d  = 1'b1;
        end
      end
      DONE: begin
        state_d    = enable ? STREAM : IDLE;
        clr_issued = enable;
      end
      default: state_d = IDLE;
    endcase
    inflight = 3'(occ) + 3'(rd_q) + 3'(cap_q);
    rd_d     = (state_q == STREAM)
            && (bus.data_count_r > (COUNT_WIDTH'(rd_q) + COUNT_WIDTH'(cap_q)))
            && (inflight < 3'd2)
            && (issued_q < IW'(FSIZE));
    issued_d = clr_issued ? '0 : issued_q + IW'(rd_d);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      x_q          <= '0;
      y_q          <= '0;
      issued_q     <= '0;
      rd_q         <= 1'b0;
      cap_q        <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      x_q          <= x_d;
      y_q          <= y_d;
      issued_q     <= issued_d;
      rd_q         <= rd_d;
      cap_q        <= rd_q;
      frame_done_q <= done_d;
    end
  end

  sr_stream_skid_buf #(.DW(DW)) u_skid (
    .clk   (clk),
    .rst   (rst),
    .push  (cap_q),
    .din   (wr_data),
    .ready (bus.m_ready),
    .valid (valid),
    .dout  (head),
    .occ   (occ)
  );

  assign bus.rd_fifo = rd_q;
  assign bus.m_valid = valid;
  assign bus.m_data  = head[PIXEL_WIDTH-1:0];
  assign bus.m_sof   = head[DW-1];
  assign bus.m_eol   = head[DW-2];
  assign frame_done  = frame_done_q;

`ifdef SR_READER_UNDERRUN_EN
  logic [15:0] underrun_q;

  // Downstream ready but nothing to give mid-frame.
  always_ff @(posedge clk) begin
    if (rst) begin
      underrun_q <= 16'd0;
    end else if ((state_q == STREAM) && bus.m_ready && !valid && (underrun_q != 16'hFFFF)) begin
      underrun_q <= underrun_q + 16'd1;
    end
  end

  assign underrun_count = underrun_q;
`else
  assign underrun_count = 16'd0;
`endif

endmodule
